// File: rtl/regfile_multiport_if.sv
// Bus bundle for regfile_multiport: read addresses/data, write port and status flags.
// Decode/write-back side uses master; the register file uses slave.
interface regfile_multiport_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int NREAD  = 2
);
    logic [NREAD*ADDR_W-1:0] RA;
    logic [NREAD*DATA_W-1:0] BusR;
    logic [ADDR_W-1:0]       RW;
    logic [DATA_W-1:0]       BusW;
    logic                    RegWr;
    logic                    Busy;
    logic                    WrDrop;

    modport master (
        output RA, RW, BusW, RegWr,
        input  BusR, Busy, WrDrop
    );

    modport slave (
        input  RA, RW, BusW, RegWr,
        output BusR, Busy, WrDrop
    );
endinterface

// File: rtl/regfile_multiport.sv
// Multi-read-port register file with a post-reset clear sequencer and dropped-write flag.
// Optional same-cycle write-to-read bypass when REGFILE_BYPASS_EN is defined.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_CLEAR | zeroing reg[ptr] one per cycle; Busy=1, writes dropped
// S_READY | normal operation until the next Reset
module regfile_multiport #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 31
) (
    input logic                 Clk,
    input logic                 Reset,
    regfile_multiport_if.slave  bus
);
    localparam int              DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_ptr;
    logic [ADDR_W-1:0]   w_ptr_nxt;
    logic                r_wrdrop;
    logic                w_busy;
    logic                w_clr_en;
    logic                w_wr_en;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_CLEAR;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_busy      = 1'b0;
        w_clr_en    = 1'b0;
        case (r_state)
            S_CLEAR: begin
                w_busy    = 1'b1;
                w_clr_en  = 1'b1;
                w_ptr_nxt = r_ptr + 1'b1;
                if (r_ptr == LAST_IDX) begin
                    w_state_nxt = S_READY;
                end
            end
            S_READY: begin
                w_state_nxt = S_READY;
            end
        endcase
    end

    // ZERO_REG writes are discarded silently; only Busy-time writes count as drops.
    assign w_wr_en = bus.RegWr && !w_busy && (bus.RW != ZERO_IDX);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_wrdrop <= 1'b0;
        end else begin
            r_wrdrop <= bus.RegWr && w_busy;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            if (w_clr_en) begin
                r_mem[r_ptr] <= '0;
            end else if (w_wr_en) begin
                r_mem[bus.RW] <= bus.BusW;
            end
        end
    end

    assign bus.Busy   = w_busy;
    assign bus.WrDrop = r_wrdrop;

`ifdef REGFILE_BYPASS_EN
    logic w_byp_ok;
    assign w_byp_ok = bus.RegWr && (r_state == S_READY) && (bus.RW != ZERO_IDX);
`endif

    for (genvar gi = 0; gi < NREAD; gi++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        logic [DATA_W-1:0] w_rd;

        assign w_ra = bus.RA[gi*ADDR_W +: ADDR_W];

        always_comb begin
            w_rd = '0;
            if (!w_busy && (w_ra != ZERO_IDX)) begin
`ifdef REGFILE_BYPASS_EN
                if (w_byp_ok && (w_ra == bus.RW)) begin
                    w_rd = bus.BusW;
                end else begin
                    w_rd = r_mem[w_ra];
                end
`else
                w_rd = r_mem[w_ra];
`endif
            end
        end

        assign bus.BusR[gi*DATA_W +: DATA_W] = w_rd;
    end
endmodule
